muldiv_hilo_controller: RTL and testbench
=========================================

// Module: muldiv_hilo_controller
// PURPOSE
//  Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage.
//  Takes mult/multu/div/divu from the issue logic. Runs them over several cycles
//  while the pipeline stalls on busy, then commits the result to HI/LO. Serves
//  mfhi/mflo reads and mthi/mtlo writes. Keeps long-latency ops off the
//  single-cycle ALU path.
// PARAMETERS
//  WIDTH         32  operand / HI / LO width; the divide iterates WIDTH cycles
//  MULT_LATENCY  4   cycles from accepted start to multiply commit (>=1)
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      synchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  op        in   2      00 mult, 01 multu, 10 div, 11 divu
//  src_a     in   WIDTH  multiplicand / dividend
//  src_b     in   WIDTH  multiplier / divisor
//  flush     in   1      cancel the in-flight op (EX squash)
//  hi_we     in   1      mthi strobe
//  lo_we     in   1      mtlo strobe
//  wdata     in   WIDTH  mthi/mtlo data
//  busy      out  1      op in flight; issue logic stalls mult/div/mf*/mt*
//  done      out  1      one-cycle pulse in the cycle HI/LO first show a new result
//  hi        out  WIDTH  HI register (remainder / product[2W-1:W])
//  lo        out  WIDTH  LO register (quotient / product[W-1:0])
// BEHAVIOUR
//  - Reset values: hi=0, lo=0, busy=0, done=0, FSM=IDLE.
//    Reset mid-operation aborts the op; nothing commits.
//  - FSM states: IDLE, MUL, DIV, FIX.
//    IDLE -start&!flush-> MUL (op[1]=0) or DIV (op[1]=1).
//    MUL  -count==MULT_LATENCY-1-> IDLE, commit.
//    DIV  -WIDTH iterations-> FIX.
//    FIX  -1 cycle-> IDLE, commit.
//  - Operands and op are latched on the accepting edge. Later changes on
//    src_a/src_b/op have no effect.
//  - Latency: start accepted at edge N. The commit edge is N+MULT_LATENCY
//    (multiply) or N+WIDTH+1 (divide). After the commit edge, hi/lo hold the
//    result and done=1 for exactly one cycle.
//  - busy=1 from the cycle after the accepting edge through the commit edge.
//    busy=0 in the cycle where done=1.
//  - Multiply: full 2W-bit product; signed for mult, unsigned for multu.
//    {hi,lo} = product.
//  - Divide: restoring, one quotient bit per cycle on magnitudes. FIX applies
//    the signs: the quotient is negated if sign(a)^sign(b); the remainder takes
//    the sign of the dividend. div of INT_MIN by -1 gives lo=INT_MIN, hi=0 (wrap).
//  - start while busy: ignored; no queueing.
//    flush with start in the same cycle: start is ignored.
//  - flush while busy: FSM goes to IDLE on that edge. busy=0 next cycle,
//    no done, HI/LO unchanged.
//  - hi_we/lo_we in IDLE: write on that edge; read-back value appears next cycle.
//    If start is accepted on the same edge, the write still lands and the op
//    result overwrites it at commit.
//  - hi_we/lo_we while busy: ignored.
//  - hi/lo are direct register outputs. A read in the done cycle sees the new result.
// CONFIGURATION
//  MULDIV_DIVZERO_EN defined:
//    - div/divu with src_b==0 skips the iteration and commits on edge N+1:
//      hi=src_a, lo={WIDTH{1'b1}}, done pulses.
//  MULDIV_DIVZERO_EN undefined:
//    - a divide by zero runs the full WIDTH+1 cycles and pulses done.
//    - HI/LO are left unchanged (result discarded).
// TESTING
//  1 mult a=2000000000, b=3 -> done at N+4; hi=00000001, lo=65a0bc00.
//  2 multu a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//    mult of the same operands -> hi=00000000, lo=00000001.
//  3 div a=11, b=3 -> busy for 33 cycles, then done; hi=2, lo=3.
//    div a=-7, b=2 -> hi=FFFFFFFF, lo=FFFFFFFD.
//    divu a=FFFFFFF9, b=2 -> hi=1, lo=7FFFFFFC.
//  4 div started, flush after 10 busy cycles -> busy=0 next cycle, no done,
//    hi/lo keep their prior values. A new start is accepted the following cycle.
//  5 hi_we=1 with wdata=DEADBEEF in IDLE -> hi=DEADBEEF.
//    hi_we while busy -> hi unchanged.
//    start asserted while busy -> no second done.
//    Reset mid-divide -> hi=lo=0, busy=0.
//  6 div a=5, b=0:
//    with MULDIV_DIVZERO_EN -> done at N+1, hi=5, lo=FFFFFFFF.
//    without it -> done at N+33, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_hilo_controller.sv
// muldiv_hilo_controller: multi-cycle multiply/divide sequencer and owner of
// the HI/LO registers for the EX stage. A multiply commits MULT_LATENCY
// cycles after it is accepted. A divide runs a restoring loop, one quotient
// bit per cycle on operand magnitudes, followed by a sign-fix cycle.
// Build option: define MULDIV_DIVZERO_EN to make a divide by zero commit
// hi=src_a, lo=all-ones after one cycle. When it is undefined, a divide by
// zero runs the full length, pulses done and leaves HI/LO untouched.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted
// MUL   | multiply in flight, counting down to commit
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | apply quotient/remainder signs and commit
module muldiv_hilo_controller #(
  parameter int WIDTH        = 32,
  parameter int MULT_LATENCY = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_MAX = (WIDTH > MULT_LATENCY) ? WIDTH : MULT_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  // quo_q holds the multiplicand / dividend magnitude, then the quotient
  logic [WIDTH-1:0] quo_q, quo_d;
  // dvs_q holds the multiplier / divisor magnitude
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               op_signed, b_zero;

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v,
                                             input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Sign/zero extension to 2W bits lets one truncated product serve both
  // signed and unsigned multiplies.
  assign mul_a    = sgn_q ? {{WIDTH{quo_q[WIDTH-1]}}, quo_q} : {{WIDTH{1'b0}}, quo_q};
  assign mul_b    = sgn_q ? {{WIDTH{dvs_q[WIDTH-1]}}, dvs_q} : {{WIDTH{1'b0}}, dvs_q};
  assign prod     = mul_a * mul_b;
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};
  assign op_signed = ~op_i[0];
  assign b_zero    = (src_b_i == '0);

  // Next-state, datapath and commit decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i && !flush_i) begin
          sgn_d  = op_signed;
          rem_d  = '0;
          if (op_i[1]) begin
            dz_d   = b_zero;
            qneg_d = op_signed && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
            rneg_d = op_signed && src_a_i[WIDTH-1];
            quo_d  = b_zero ? src_a_i : abs_f(src_a_i, op_signed);
            dvs_d  = abs_f(src_b_i, op_signed);
            cnt_d  = DIV_LOAD;
`ifdef MULDIV_DIVZERO_EN
            state_d = b_zero ? S_FIX : S_DIV;
`else
            state_d = S_DIV;
`endif
          end else begin
            dz_d    = 1'b0;
            quo_d   = src_a_i;
            dvs_d   = src_b_i;
            cnt_d   = MUL_LOAD;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (!rem_diff[WIDTH]) begin
            rem_d = rem_diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (!dz_q) begin
            hi_d = neg_if(rem_q, rneg_q);
            lo_d = neg_if(quo_q, qneg_q);
          end
`ifdef MULDIV_DIVZERO_EN
          else begin
            hi_d = quo_q;
            lo_d = '1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath, HI/LO and done registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      sgn_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sgn_q  <= sgn_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_controller.sv
// Testbench for muldiv_hilo_controller: spec vector table, randomized ops
// against an arithmetic reference model, and hand-written corner sequences.
module tb_muldiv_hilo_controller;

  localparam int W = 32;
  localparam int L = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          flush, hi_we, lo_we;
  logic [W-1:0]  wdata;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int checks;
  int failures;
  logic [W-1:0] m_hi, m_lo;

  muldiv_hilo_controller #(.WIDTH(W), .MULT_LATENCY(L)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
    .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] rh,
                                 output logic [W-1:0] rl, output int lat,
                                 output bit wr);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0; rl = '0; wr = 1'b1; lat = W + 1;
    case (o)
      2'b00: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; lat = L; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; lat = L; end
      default: begin
        if (b == 0) begin
`ifdef MULDIV_DIVZERO_EN
          rh = a; rl = 32'hFFFF_FFFF; lat = 1;
`else
          wr = 1'b0;
`endif
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          rl = q[31:0]; rh = r[31:0];
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input int lat,
                        input string name);
    int k;
    int busy_cnt;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    k = 0; busy_cnt = 0;
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      k++;
    end
    chk({name, "_latency"}, 64'(k), 64'(lat));
    chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
    chk({name, "_busy_in_done"}, 64'(busy), 64'(0));
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
    tick();
    chk({name, "_done_one_cycle"}, 64'(done), 64'(0));
  endtask

  task automatic run_model(input logic [1:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input string name);
    logic [W-1:0] rh, rl;
    int lat;
    bit wr;
    ref_op(o, a, b, rh, rl, lat, wr);
    if (wr) begin m_hi = rh; m_lo = rl; end
    run_op(o, a, b, m_hi, m_lo, lat, name);
  endtask

  initial begin
    int dcount;
    logic [W-1:0] a, b;
    logic [1:0] o;
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    tbl[0] = '{2'b00, 32'd2000000000, 32'd3, 32'h0000_0001, 32'h65A0_BC00};
    tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    tbl[3] = '{2'b10, 32'd11, 32'd3, 32'h0000_0002, 32'h0000_0003};
    tbl[4] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[5] = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC};
    tbl[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[8] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[9] = '{2'b11, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 32'hFFFF_FFFF};

    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el,
             tbl[i].op[1] ? W + 1 : L, $sformatf("vec%0d", i));
      m_hi = tbl[i].eh; m_lo = tbl[i].el;
    end

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 5));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_model(o, a, b, $sformatf("rand%0d", i));
    end

    // flush after 10 busy cycles
    start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("flush_busy_before", 64'(busy), 64'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'(0));
    chk("flush_no_done", 64'(done), 64'(0));
    chk("flush_hi_kept", 64'(hi), 64'(m_hi));
    chk("flush_lo_kept", 64'(lo), 64'(m_lo));
    run_model(2'b01, 32'd6, 32'd7, "after_flush");

    // mthi / mtlo in IDLE
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h1234_5678;
    chk("mthi_idle", 64'(hi), 64'(32'hDEAD_BEEF));
    tick();
    lo_we = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'(32'h1234_5678));
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234_5678;

    // mthi and start while busy are ignored; exactly one done
    start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    tick();
    op = 2'b10; src_a = 32'd1; src_b = 32'd1;
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    tick();
    chk("mthi_busy_ignored", 64'(hi), 64'(32'hDEAD_BEEF));
    tick();
    start = 1'b0; hi_we = 1'b0;
    dcount = 0;
    for (int i = 0; i < 45; i++) begin
      if (done === 1'b1) dcount++;
      tick();
    end
    chk("start_busy_single_done", 64'(dcount), 64'(1));
    chk("start_busy_hi", 64'(hi), 64'(0));
    chk("start_busy_lo", 64'(lo), 64'(81));
    m_hi = '0; m_lo = 32'd81;

    // mthi landing on the accepting edge, then overwritten by the result
    hi_we = 1'b1; wdata = 32'hCAFE_0001;
    start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd5;
    tick();
    hi_we = 1'b0; start = 1'b0;
    chk("mthi_with_start", 64'(hi), 64'(32'hCAFE_0001));
    dcount = 0;
    while (done !== 1'b1 && dcount < 100) begin tick(); dcount++; end
    chk("mthi_start_result_hi", 64'(hi), 64'(0));
    chk("mthi_start_result_lo", 64'(lo), 64'(15));
    tick();

    // start with flush in the same cycle is dropped
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd2;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start_flush_ignored", 64'(busy), 64'(0));
    m_hi = '0; m_lo = 32'd15;

    // divide by zero
    run_model(2'b10, 32'd5, 32'd0, "divzero");

    // reset mid-divide
    start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_hi", 64'(hi), 64'(0));
    chk("reset_mid_lo", 64'(lo), 64'(0));
    chk("reset_mid_busy", 64'(busy), 64'(0));
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dcount++;
      tick();
    end
    chk("reset_mid_no_done", 64'(dcount), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
